if_stage_fifo: RTL and testbench
================================

Name: if_stage_fifo

Overview:
Parametrised instruction-fetch stage for the 5-stage LoongArch pipeline. It drives a synchronous-read instruction SRAM with 1-cycle read latency and queues returned instructions with their PCs in a small FIFO. It hands instructions to the decode stage through a valid/allowin handshake and flushes all queued and in-flight fetches on a taken branch. Unlike the previous fetch stage, it tolerates decode back-pressure without losing or duplicating instructions.

Parameters:
- RESET_PC, 32'h1c000000: address of the first fetch after reset.
- ADDR_W, 32: PC / SRAM address width.
- INST_W, 32: instruction width.
- BUF_DEPTH, 2: FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- fs_valid  out  1  FIFO head holds a valid instruction.
- ds_allowin  in  1  decode accepts the head this cycle.
- fs_to_ds_bus  out  INST_W+ADDR_W  {inst, pc} of the FIFO head.
- br_taken  in  1  taken-branch redirect (1-cycle pulse from decode).
- br_target  in  ADDR_W  redirect address.
- inst_sram_en  out  1  read request.
- inst_sram_we  out  4  tied to 0.
- inst_sram_addr  out  ADDR_W  request address.
- inst_sram_wdata  out  32  tied to 0.
- inst_sram_rdata  in  INST_W  read data, valid the cycle after the request.

Behaviour:
- State:
  - pc_req: next sequential request address.
  - pend, pend_pc: one outstanding request and its PC.
  - FIFO storage, rd_ptr, wr_ptr, count.
- Reset (asynchronous, on the assert edge):
  - pc_req=RESET_PC; pend=0; count=0; pointers=0.
  - Outputs while reset is high: fs_valid=0, inst_sram_en=0, fs_to_ds_bus=0.
- pop = fs_valid & ds_allowin. Pop takes effect at the clock edge.
- Issue rule:
  - issue = br_taken | ((count + pend - pop) < BUF_DEPTH).
  - inst_sram_en = issue. inst_sram_addr = br_taken ? br_target : pc_req.
  - On issue: pend<=1, pend_pc<=addr, pc_req<=addr+4 (mod 2^ADDR_W, wraps silently).
  - No issue: pend<=0.
- Response:
  - In the cycle after an issue (pend=1), {inst_sram_rdata, pend_pc} is pushed at the clock edge, unless br_taken is high that cycle.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - The credit rule guarantees a push never finds the FIFO full. An overflow is a design error; assert it in simulation.
- Latency:
  - Request issued in cycle t, rdata in cycle t+1, fs_valid=1 in cycle t+2.
  - After reset deasserts, the first request (RESET_PC) issues in the first cycle and the first instruction appears 2 cycles later.
- Throughput: 1 instruction per cycle in steady state while ds_allowin=1 and BUF_DEPTH>=2.
- Flush (br_taken=1):
  - At the edge: count<=0, rd_ptr=wr_ptr<=0.
  - The response returning this cycle is discarded.
  - The same cycle issues a request to br_target. Its data is pushed next cycle, so the first target instruction is valid 2 cycles after br_taken.
  - The pop in the flush cycle still counts as consumed by decode.
  - br_taken has priority over credit: the redirect request is always issued.
- Back-pressure:
  - With ds_allowin=0, the FIFO fills to BUF_DEPTH and then issue stops. inst_sram_en stays 0 until a pop frees a credit.
  - fs_to_ds_bus stays stable while fs_valid=1 and ds_allowin=0.
- Reset asserted mid-operation clears all entries and the pending request immediately. The late SRAM response is ignored because pend=0.
- br_taken while reset is high is ignored.

Test Plan:
- Reset release, ds_allowin=1 constant -> inst_sram_addr sequence 0x1c000000, 0x1c000004, ... one per cycle. fs_valid rises 2 cycles after the first request. Bus pc values match the addresses in order.
- ds_allowin=0 for 6 cycles from steady state, BUF_DEPTH=2 -> count saturates at 2, inst_sram_en=0 once full. On release, pcs continue with no gap or duplicate (e.g. 0x1c000010 followed by 0x1c000014).
- br_taken with br_target=0x1c000100 while 2 entries are buffered and 1 request is in flight -> inst_sram_addr=0x1c000100 that cycle, the old in-flight data is dropped, fs_valid=0 for the next cycle, then the bus pc is 0x1c000100, then 0x1c000104.
- br_taken in the same cycle as ds_allowin=0 and a full FIFO -> the redirect still issues and the FIFO empties. Only target-path pcs appear afterwards.
- Reset asserted between clock edges mid-stream -> fs_valid and inst_sram_en drop to 0 immediately. After release, fetch restarts at RESET_PC.
- BUF_DEPTH=4, pc_req near 0xFFFFFFFC (via br_target=0xFFFFFFFC) -> the next request is 0x00000000 (wrap). With ds_allowin held low, exactly 4 entries are accepted and then issue stops.

Source files
------------

// File: rtl/if_stage_fifo.sv
// Instruction-fetch stage: drives a 1-cycle-latency instruction SRAM and
// buffers returned {inst, pc} pairs in a small FIFO towards decode.
module if_stage_fifo #(
   parameter int                ADDR_W    = 32,
   parameter int                INST_W    = 32,
   parameter int                BUF_DEPTH = 2,
   parameter logic [ADDR_W-1:0] RESET_PC  = 32'h1c000000
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     fs_valid,
   input  logic                     ds_allowin,
   output logic [INST_W+ADDR_W-1:0] fs_to_ds_bus,
   input  logic                     br_taken,
   input  logic [ADDR_W-1:0]        br_target,
   output logic                     inst_sram_en,
   output logic [3:0]               inst_sram_we,
   output logic [ADDR_W-1:0]        inst_sram_addr,
   output logic [31:0]              inst_sram_wdata,
   input  logic [INST_W-1:0]        inst_sram_rdata
);

   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int OCC_W = CNT_W + 1;

   logic [ADDR_W-1:0] pc_req;
   logic [ADDR_W-1:0] pend_pc;
   logic [ADDR_W-1:0] req_addr;
   logic              pend;

   logic [INST_W-1:0] inst_mem [BUF_DEPTH];
   logic [ADDR_W-1:0] pc_mem   [BUF_DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;
   logic [OCC_W-1:0]  occ;

   logic pop;
   logic push;
   logic issue;

   assign fs_valid = (count != '0) & ~reset;
   assign pop      = fs_valid & ds_allowin;
   assign push     = pend & ~br_taken;

   // Entries held after this edge plus the one still in flight.
   assign occ   = OCC_W'(count) + OCC_W'(pend) - OCC_W'(pop);
   assign issue = ~reset & (br_taken | (occ < OCC_W'(BUF_DEPTH)));

   assign req_addr        = br_taken ? br_target : pc_req;
   assign inst_sram_en    = issue;
   assign inst_sram_addr  = req_addr;
   assign inst_sram_we    = 4'b0;
   assign inst_sram_wdata = 32'b0;

   assign fs_to_ds_bus = fs_valid ? {inst_mem[rd_ptr], pc_mem[rd_ptr]} : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_req  <= RESET_PC;
         pend    <= 1'b0;
         pend_pc <= '0;
      end else begin
         pend <= issue;
         if (issue) begin
            pend_pc <= req_addr;
            pc_req  <= req_addr + ADDR_W'(4);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (br_taken) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         inst_mem[wr_ptr] <= inst_sram_rdata;
         pc_mem[wr_ptr]   <= pend_pc;
      end
   end

   // The credit rule must keep a push from ever landing on a full buffer.
   always @(posedge clk) begin
      if (!reset && push && !pop)
         assert (count < CNT_W'(BUF_DEPTH));
   end

endmodule

// File: tb/tb_if_stage_fifo.sv
// Bench for if_stage_fifo: depth-2 and depth-4 instances share stimulus
// and are checked against a queue-level model of the fetch stage.
module tb_if_stage_fifo;

   logic        clk = 1'b0;
   logic        reset;
   logic        ds_allowin;
   logic        br_taken;
   logic [31:0] br_target;

   logic        valid_o [2];
   logic [63:0] bus_o   [2];
   logic        en_o    [2];
   logic [3:0]  we_o    [2];
   logic [31:0] addr_o  [2];
   logic [31:0] wdata_o [2];
   logic [31:0] rdata_i [2];

   always #5 clk = ~clk;

   if_stage_fifo #(.BUF_DEPTH(2)) u_d2 (
      .clk             (clk),
      .reset           (reset),
      .fs_valid        (valid_o[0]),
      .ds_allowin      (ds_allowin),
      .fs_to_ds_bus    (bus_o[0]),
      .br_taken        (br_taken),
      .br_target       (br_target),
      .inst_sram_en    (en_o[0]),
      .inst_sram_we    (we_o[0]),
      .inst_sram_addr  (addr_o[0]),
      .inst_sram_wdata (wdata_o[0]),
      .inst_sram_rdata (rdata_i[0])
   );

   if_stage_fifo #(.BUF_DEPTH(4)) u_d4 (
      .clk             (clk),
      .reset           (reset),
      .fs_valid        (valid_o[1]),
      .ds_allowin      (ds_allowin),
      .fs_to_ds_bus    (bus_o[1]),
      .br_taken        (br_taken),
      .br_target       (br_target),
      .inst_sram_en    (en_o[1]),
      .inst_sram_we    (we_o[1]),
      .inst_sram_addr  (addr_o[1]),
      .inst_sram_wdata (wdata_o[1]),
      .inst_sram_rdata (rdata_i[1])
   );

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return {a[15:0] ^ 16'h5a5a, ~a[31:16]};
   endfunction

   always @(posedge clk) if (en_o[0]) rdata_i[0] <= inst_of(addr_o[0]);
   always @(posedge clk) if (en_o[1]) rdata_i[1] <= inst_of(addr_o[1]);

   int total = 0;
   int bad   = 0;

   logic [31:0] mq    [2][8];
   int          mn    [2];
   bit          mpend [2];
   logic [31:0] mpc   [2];
   logic [31:0] mpreq [2];

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic reset_cycle(input int i);
      chk($sformatf("rst_en%0d", i), 64'(en_o[i]), 64'd0);
      chk($sformatf("rst_valid%0d", i), 64'(valid_o[i]), 64'd0);
      chk($sformatf("rst_bus%0d", i), bus_o[i], 64'd0);
      mn[i]    = 0;
      mpend[i] = 1'b0;
      mpreq[i] = 32'h1c000000;
   endtask

   task automatic model_cycle(input int i);
      int          d;
      bit          ev;
      bit          pp;
      bit          iss;
      logic [31:0] a;
      logic [63:0] eb;
      d   = (i == 0) ? 2 : 4;
      ev  = mn[i] > 0;
      eb  = ev ? {inst_of(mq[i][0]), mq[i][0]} : 64'd0;
      pp  = ev && ds_allowin;
      iss = br_taken || ((mn[i] + int'(mpend[i]) - int'(pp)) < d);
      a   = br_taken ? br_target : mpreq[i];
      chk($sformatf("d%0d_valid", d), 64'(valid_o[i]), 64'(ev));
      chk($sformatf("d%0d_bus", d), bus_o[i], eb);
      chk($sformatf("d%0d_en", d), 64'(en_o[i]), 64'(iss));
      chk($sformatf("d%0d_addr", d), 64'(addr_o[i]), 64'(a));
      chk($sformatf("d%0d_tie", d), {we_o[i], wdata_o[i]}, 64'd0);
      if (br_taken) begin
         mn[i] = 0;
      end else begin
         if (pp) begin
            for (int k = 0; k < 7; k++) mq[i][k] = mq[i][k+1];
            mn[i]--;
         end
         if (mpend[i]) begin
            mq[i][mn[i]] = mpc[i];
            mn[i]++;
         end
      end
      mpend[i] = iss;
      if (iss) begin
         mpc[i]   = a;
         mpreq[i] = a + 32'd4;
      end
   endtask

   task automatic step(input bit r, input bit a, input bit b,
                       input logic [31:0] t);
      @(negedge clk);
      reset      = r;
      ds_allowin = a;
      br_taken   = b;
      br_target  = t;
      #1;
      for (int i = 0; i < 2; i++) begin
         if (reset) reset_cycle(i);
         else       model_cycle(i);
      end
   endtask

   initial begin
      reset      = 1'b0;
      ds_allowin = 1'b0;
      br_taken   = 1'b0;
      br_target  = 32'h0;
      #1 reset   = 1'b1;
      step(1, 0, 0, 32'h0);
      step(1, 1, 1, 32'h1c000200);
      for (int n = 0; n < 10; n++) step(0, 1, 0, 32'h0);
      for (int n = 0; n < 6; n++)  step(0, 0, 0, 32'h0);
      for (int n = 0; n < 4; n++)  step(0, 1, 0, 32'h0);
      step(0, 0, 0, 32'h0);
      step(0, 1, 1, 32'h1c000100);
      for (int n = 0; n < 4; n++)  step(0, 1, 0, 32'h0);
      for (int n = 0; n < 4; n++)  step(0, 0, 0, 32'h0);
      step(0, 0, 1, 32'h1c000200);
      for (int n = 0; n < 4; n++)  step(0, 1, 0, 32'h0);
      step(1, 1, 0, 32'h0);
      step(1, 1, 1, 32'h1c000300);
      for (int n = 0; n < 4; n++)  step(0, 1, 0, 32'h0);
      step(0, 0, 1, 32'hfffffffc);
      for (int n = 0; n < 8; n++)  step(0, 0, 0, 32'h0);
      for (int n = 0; n < 6; n++)  step(0, 1, 0, 32'h0);
      for (int n = 0; n < 400; n++) begin
         step(($urandom % 60) == 0, ($urandom % 4) != 0,
              ($urandom % 12) == 0, $urandom & 32'hfffffffc);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
